// File: rtl/sh2_ld_pkg.sv
// Shared types and helpers for the SH2 load-return writeback stage.
//   ld_size_t  : access size of a pending load
//   ld_entry_t : one pending-load record (destination, size, address low bits)
//   ld_align   : big-endian lane select plus sign extension to 32 bits
package sh2_ld_pkg;

    localparam int unsigned PR_IDX   = 16;
    localparam int unsigned NUM_REGS = 17;  // R0-R15 plus PR

    typedef enum logic [1:0] {
        LD_B = 2'b00,
        LD_W = 2'b01,
        LD_L = 2'b10
    } ld_size_t;

    typedef struct packed {
        logic [4:0] rn;
        ld_size_t   size;
        logic [1:0] alo;
    } ld_entry_t;

    // Encoding 2'b11 is reserved and behaves as a long access.
    function automatic ld_size_t to_ld_size(input logic [1:0] raw);
        unique case (raw)
            2'b00:   return LD_B;
            2'b01:   return LD_W;
            default: return LD_L;
        endcase
    endfunction

    function automatic logic [31:0] ld_align(input logic [31:0] data,
                                             input ld_size_t    size,
                                             input logic [1:0]  alo);
        logic [7:0]  b;
        logic [15:0] h;
        unique case (alo)
            2'd0:    b = data[31:24];
            2'd1:    b = data[23:16];
            2'd2:    b = data[15:8];
            default: b = data[7:0];
        endcase
        // Word accesses ignore alo[0].
        h = alo[1] ? data[15:0] : data[31:16];
        unique case (size)
            LD_B:    return {{24{b[7]}}, b};
            LD_W:    return {{16{h[15]}}, h};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/sh2_ld_queue.sv
// In-order pending-load FIFO for the SH2 load writeback stage.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset (clears pointers/count)
//   push, push_entry: append an entry (caller guarantees not full)
//   pop, head       : remove / observe the oldest entry (caller guarantees not empty)
//   full, empty     : occupancy flags
//   count           : number of valid entries, 0..DEPTH
//   match           : bit r set when any valid entry targets register r
module sh2_ld_queue
    import sh2_ld_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  ld_entry_t                  push_entry,
    input  logic                       pop,
    output ld_entry_t                  head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [NUM_REGS-1:0]        match
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    ld_entry_t         mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        logic [PW-1:0] off;
        match = '0;
        off   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr_q;
            if (({1'b0, off} < count_q) && (mem_q[i].rn <= 5'(PR_IDX))) begin
                match[mem_q[i].rn] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sh2_load_wb.sv
// SH2 load-return writeback stage, feeding register-file write port B.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   ce, en              : pipeline clock-enable, global enable (en=0 freezes all state)
//   ld_issue/rn/size/alo: load issued by decode (accepted on ce&en when not full)
//   bus_rdy, bus_di     : read data return, big-endian lanes
//   chk_a_*, chk_b_*    : decode source registers to test against pending loads
//   stall               : hazard with a pending load, or issue while full
//   ld_full             : pending queue holds DEPTH loads
//   wb_addr, wb_d, wbe  : register-file port B, held until consumed on ce&en
//   err                 : sticky [0] issue while full, [1] overrun / return with empty queue
module sh2_load_wb
    import sh2_ld_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic        en,
    input  logic        ld_issue,
    input  logic [4:0]  ld_rn,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_alo,
    input  logic        bus_rdy,
    input  logic [31:0] bus_di,
    input  logic [4:0]  chk_a_addr,
    input  logic        chk_a_v,
    input  logic [4:0]  chk_b_addr,
    input  logic        chk_b_v,
    output logic        stall,
    output logic        ld_full,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_d,
    output logic        wbe,
    output logic [1:0]  err
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    ld_entry_t           push_entry;
    ld_entry_t           head;
    logic                q_full;
    logic                q_empty;
    logic [CW-1:0]       q_count;
    logic [NUM_REGS-1:0] match;

    logic                push;
    logic                pop;
    logic                consume;

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [4:0]          wb_addr_q, wb_addr_d;
    logic [31:0]         wb_d_q, wb_d_d;
    logic                wbe_q, wbe_d;
    logic [1:0]          err_q, err_d;

    assign push    = ce & en & ld_issue & ~q_full;
    assign pop     = en & bus_rdy & ~q_empty;
    assign consume = ce & wbe_q;

    assign push_entry = '{rn: ld_rn, size: to_ld_size(ld_size), alo: ld_alo};

    sh2_ld_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .full       (q_full),
        .empty      (q_empty),
        .count      (q_count),
        .match      (match)
    );

    always_comb begin
        // On consumption every busy bit is rebuilt from the queue contents; this also
        // releases any register whose writeback was overwritten while ce was low.
        // The queue still holds the head being popped, so it stays busy in wb_*.
        busy_d = consume ? match : busy_q;
        // Issue sets after the clear so a same-cycle issue to the consumed register wins.
        if (push) begin
            busy_d = busy_d | NUM_REGS'(32'd1 << ld_rn);
        end

        wb_addr_d = wb_addr_q;
        wb_d_d    = wb_d_q;
        wbe_d     = wbe_q;
        if (pop) begin
            wb_addr_d = head.rn;
            wb_d_d    = ld_align(bus_di, head.size, head.alo);
            wbe_d     = 1'b1;
        end else if (consume) begin
            wbe_d = 1'b0;
        end

        err_d = err_q;
        if (ce && ld_issue && q_full) begin
            err_d[0] = 1'b1;
        end
        if (bus_rdy && (q_empty || (wbe_q && !ce))) begin
            err_d[1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q    <= '0;
            wb_addr_q <= '0;
            wb_d_q    <= '0;
            wbe_q     <= 1'b0;
            err_q     <= '0;
        end else if (en) begin
            busy_q    <= busy_d;
            wb_addr_q <= wb_addr_d;
            wb_d_q    <= wb_d_d;
            wbe_q     <= wbe_d;
            err_q     <= err_d;
        end
    end

    // Widened so out-of-range check addresses read as not busy.
    logic [31:0] busy_ext;
    assign busy_ext = {15'd0, busy_q};

    assign stall   = (chk_a_v & busy_ext[chk_a_addr]) |
                     (chk_b_v & busy_ext[chk_b_addr]) |
                     (ld_issue & ld_full);
    assign ld_full = (q_count == CW'(DEPTH));
    assign wb_addr = wb_addr_q;
    assign wb_d    = wb_d_q;
    assign wbe     = wbe_q;
    assign err     = err_q;

endmodule

// File: tb/tb_sh2_load_wb.sv
module tb_sh2_load_wb;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n, ce, en, ld_issue, bus_rdy, chk_a_v, chk_b_v;
    logic [4:0]  ld_rn, chk_a_addr, chk_b_addr;
    logic [1:0]  ld_size, ld_alo;
    logic [31:0] bus_di;
    logic        stall, ld_full, wbe;
    logic [4:0]  wb_addr;
    logic [31:0] wb_d;
    logic [1:0]  err;

    int errors = 0;
    int checks = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    sh2_load_wb #(
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce         (ce),
        .en         (en),
        .ld_issue   (ld_issue),
        .ld_rn      (ld_rn),
        .ld_size    (ld_size),
        .ld_alo     (ld_alo),
        .bus_rdy    (bus_rdy),
        .bus_di     (bus_di),
        .chk_a_addr (chk_a_addr),
        .chk_a_v    (chk_a_v),
        .chk_b_addr (chk_b_addr),
        .chk_b_v    (chk_b_v),
        .stall      (stall),
        .ld_full    (ld_full),
        .wb_addr    (wb_addr),
        .wb_d       (wb_d),
        .wbe        (wbe),
        .err        (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int rn;
        int size;
        int alo;
    } ment_t;

    ment_t       mq[$];
    int          lost[$];
    bit [16:0]   mbusy;
    bit          m_wbe;
    logic [4:0]  m_addr;
    logic [31:0] m_d;
    logic [1:0]  m_err;

    function automatic logic [31:0] exp_align(input logic [31:0] di, input int size,
                                              input int alo);
        logic [7:0]  b;
        logic [15:0] h;
        if (size == 0) begin
            b = 8'(di >> ((3 - alo) * 8));
            return 32'($signed(b));
        end else if (size == 1) begin
            h = (alo >= 2) ? di[15:0] : di[31:16];
            return 32'($signed(h));
        end
        return di;
    endfunction

    function automatic bit in_queue(input int r);
        foreach (mq[i]) if (mq[i].rn == r) return 1'b1;
        return 1'b0;
    endfunction

    int    n0;
    bit    m_consume, m_ret, m_iss;
    ment_t mh, mn;

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            lost.delete();
            mbusy  = '0;
            m_wbe  = 1'b0;
            m_addr = '0;
            m_d    = '0;
            m_err  = '0;
        end else if (en) begin
            n0        = mq.size();
            m_consume = ce && m_wbe;
            m_ret     = bus_rdy && (n0 > 0);
            m_iss     = ce && ld_issue && (n0 < DEPTH);
            if (m_consume) begin
                lost.push_back(int'(m_addr));
                foreach (lost[i]) if (!in_queue(lost[i])) mbusy[lost[i]] = 1'b0;
                lost.delete();
            end
            if (m_iss) mbusy[ld_rn] = 1'b1;
            if (m_ret) begin
                mh = mq.pop_front();
                if (m_wbe && !ce) begin
                    m_err[1] = 1'b1;
                    lost.push_back(int'(m_addr));
                end
                m_addr = 5'(mh.rn);
                m_d    = exp_align(bus_di, mh.size, mh.alo);
                m_wbe  = 1'b1;
            end else if (m_consume) begin
                m_wbe = 1'b0;
            end
            if (bus_rdy && n0 == 0) m_err[1] = 1'b1;
            if (ce && ld_issue && n0 == DEPTH) m_err[0] = 1'b1;
            if (m_iss) begin
                mn.rn   = int'(ld_rn);
                mn.size = (ld_size == 2'b11) ? 2 : int'(ld_size);
                mn.alo  = int'(ld_alo);
                mq.push_back(mn);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic exp_stall;
    initial forever begin
        @(negedge clk);
        if (cmp_on) begin
            exp_stall = (chk_a_v && mbusy[chk_a_addr]) || (chk_b_v && mbusy[chk_b_addr]) ||
                        (ld_issue && mq.size() == DEPTH);
            chk("cyc_stall", 32'(stall), 32'(exp_stall));
            chk("cyc_full", 32'(ld_full), 32'(mq.size() == DEPTH));
            chk("cyc_wbe", 32'(wbe), 32'(m_wbe));
            chk("cyc_wb_addr", 32'(wb_addr), 32'(m_addr));
            chk("cyc_wb_d", wb_d, m_d);
            chk("cyc_err", 32'(err), 32'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input int rn, input int size, input int alo);
        ld_issue = 1'b1;
        ld_rn    = 5'(rn);
        ld_size  = 2'(size);
        ld_alo   = 2'(alo);
        step();
        ld_issue = 1'b0;
    endtask

    task automatic ret(input logic [31:0] di);
        bus_rdy = 1'b1;
        bus_di  = di;
        step();
        bus_rdy = 1'b0;
    endtask

    task automatic stall_on(input string name, input int rn, input logic exp);
        chk_a_addr = 5'(rn);
        chk_a_v    = 1'b1;
        #1;
        chk(name, 32'(stall), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b1; en = 1'b1;
        ld_issue = 1'b0; ld_rn = '0; ld_size = '0; ld_alo = '0;
        bus_rdy = 1'b0; bus_di = '0;
        chk_a_addr = '0; chk_a_v = 1'b0; chk_b_addr = '0; chk_b_v = 1'b0;
        step(); step();
        cmp_on = 1'b1;
        rst_n  = 1'b1;
        chk("rst_wbe", 32'(wbe), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_full", 32'(ld_full), 32'd0);

        // Byte load R3, alo=2
        issue(3, 0, 2);
        stall_on("t1_stall_pending", 3, 1'b1);
        ret(32'h1234_80CD);
        chk("t1_wbe", 32'(wbe), 32'd1);
        chk("t1_addr", 32'(wb_addr), 32'd3);
        chk("t1_data", wb_d, 32'hFFFF_FF80);
        step();
        chk("t1_wbe_drop", 32'(wbe), 32'd0);
        stall_on("t1_stall_clear", 3, 1'b0);

        // Word load R5, writeback held with ce=0
        issue(5, 1, 0);
        stall_on("t2_stall_pending", 5, 1'b1);
        ce = 1'b0;
        ret(32'h7FFE_0000);
        chk("t2_data", wb_d, 32'h0000_7FFE);
        step();
        chk("t2_wbe_held", 32'(wbe), 32'd1);
        stall_on("t2_stall_held", 5, 1'b1);
        ce = 1'b1;
        step();
        chk("t2_wbe_drop", 32'(wbe), 32'd0);
        stall_on("t2_stall_clear", 5, 1'b0);
        chk_a_v = 1'b0;

        // Full queue; reserved size treated as long
        issue(1, 2, 0);
        issue(2, 3, 1);
        chk("t3_full", 32'(ld_full), 32'd1);
        ld_issue = 1'b1; ld_rn = 5'd4; ld_size = 2'd2;
        #1;
        chk("t3_stall_full", 32'(stall), 32'd1);
        step();
        ld_issue = 1'b0;
        chk("t3_err0", 32'(err), 32'd1);
        stall_on("t3_r4_not_busy", 4, 1'b0);
        chk_a_v = 1'b0;
        ret(32'hAAAA_AAAA);
        chk("t3_addr1", 32'(wb_addr), 32'd1);
        chk("t3_data1", wb_d, 32'hAAAA_AAAA);
        chk("t3_full_drop", 32'(ld_full), 32'd0);
        ret(32'h5555_5555);
        chk("t3_addr2", 32'(wb_addr), 32'd2);
        chk("t3_data2", wb_d, 32'h5555_5555);
        step();

        // Two loads to R7
        issue(7, 0, 3);
        issue(7, 1, 2);
        ret(32'h0000_00FF);
        chk("t4_data1", wb_d, 32'hFFFF_FFFF);
        step();
        stall_on("t4_r7_still_busy", 7, 1'b1);
        ret(32'h1234_8001);
        chk("t4_data2", wb_d, 32'hFFFF_8001);
        step();
        stall_on("t4_r7_clear", 7, 1'b0);

        // Issue to R6 on the edge R6 is consumed; then issue and return together
        issue(6, 2, 0);
        ret(32'h0BAD_F00D);
        issue(6, 2, 0);
        stall_on("t4b_set_wins", 6, 1'b1);
        ld_issue = 1'b1; ld_rn = 5'd14; ld_size = 2'd2; ld_alo = 2'd0;
        ret(32'h00C0_FFEE);
        ld_issue = 1'b0;
        chk("t4b_addr", 32'(wb_addr), 32'd6);
        ret(32'h0000_0080);
        chk("t4b_addr14", 32'(wb_addr), 32'd14);
        step();
        stall_on("t4b_r6_clear", 6, 1'b0);
        stall_on("t4b_r14_clear", 14, 1'b0);

        // Overrun: second return while wbe=1 and ce=0
        issue(8, 2, 0);
        issue(9, 2, 0);
        ret(32'h1111_1111);
        chk("t5_addr8", 32'(wb_addr), 32'd8);
        ce = 1'b0;
        ret(32'h2222_2222);
        chk("t5_addr9", 32'(wb_addr), 32'd9);
        chk("t5_data", wb_d, 32'h2222_2222);
        chk("t5_err", 32'(err), 32'd3);
        step();
        chk("t5_wbe_held", 32'(wbe), 32'd1);
        stall_on("t5_r8_busy", 8, 1'b1);
        ce = 1'b1;
        step();
        chk("t5_wbe_drop", 32'(wbe), 32'd0);
        stall_on("t5_r8_clear", 8, 1'b0);
        stall_on("t5_r9_clear", 9, 1'b0);

        // en=0 freezes everything
        issue(10, 2, 0);
        ret(32'hCAFE_BABE);
        en = 1'b0;
        bus_rdy = 1'b1;
        step();
        bus_rdy = 1'b0;
        step();
        chk("t6_wbe_frozen", 32'(wbe), 32'd1);
        en = 1'b1;
        step();
        chk("t6_wbe_drop", 32'(wbe), 32'd0);

        // Reset with two loads pending
        issue(12, 2, 0);
        issue(13, 2, 0);
        chk("t7_full", 32'(ld_full), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t7_full_clr", 32'(ld_full), 32'd0);
        chk("t7_wbe", 32'(wbe), 32'd0);
        chk("t7_err_clr", 32'(err), 32'd0);
        stall_on("t7_r12_clear", 12, 1'b0);
        ret(32'h1234_5678);
        chk("t7_no_wbe", 32'(wbe), 32'd0);
        chk("t7_err1", 32'(err), 32'd2);
        chk_a_v = 1'b0;
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
